// File: rtl/mem_write_unit_pkg.sv
// Shared definitions for the store-side memory write path: widths,
// size/destination encodings, buffer entry layout and lane formatting.
`ifndef WORD
`define WORD 32
`endif

package mem_write_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] DST_PC  = 2'b00;
  localparam logic [1:0] DST_MEM = 2'b10;
  localparam logic [1:0] DST_REG = 2'bx1;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_e;

  // One buffered store, already formatted for the bus.
  typedef struct packed {
    logic [`WORD-1:0] addr;
    logic [`WORD-1:0] wdata;
    logic [3:0]       be;
  } store_entry_t;

  localparam int unsigned ENTRY_W = $bits(store_entry_t);

  // Half must be 2-byte aligned, word 4-byte aligned; size 11 never legal.
  function automatic logic store_legal(input logic [1:0] lsb, input logic [1:0] size);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (lsb[0] == 1'b0);
      SZ_WORD: ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian lane replication and byte-enable generation.
  function automatic store_entry_t format_store(input logic [`WORD-1:0] addr,
                                                input logic [`WORD-1:0] data,
                                                input logic [1:0]       size);
    store_entry_t e;
    e.addr = {addr[`WORD-1:2], 2'b00};
    e.wdata = data;
    e.be = 4'b1111;
    case (size)
      SZ_BYTE: begin
        e.wdata = {4{data[7:0]}};
        e.be = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        e.wdata = {2{data[15:0]}};
        e.be = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        e.wdata = data;
        e.be = 4'b1111;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_write_unit_store_fifo.sv
// Synchronous FIFO holding formatted stores; head entry is visible on
// data_o whenever the FIFO is non-empty.
module store_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 68
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign data_o   = mem_q[rd_ptr_q];
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_write_unit.sv
// Store-side consumer of the memory-destination result path: validates and
// formats stores, buffers them, and issues them on the data-memory bus with
// a req/ack handshake and a drop-on-timeout guard.
module mem_write_unit
  import mem_write_unit_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [`WORD-1:0]   wr_addr,
  input  logic [`WORD-1:0]   wr_data,
  input  logic [1:0]         wr_size,
  output logic               bus_req,
  output logic [`WORD-1:0]   bus_addr,
  output logic [`WORD-1:0]   bus_wdata,
  output logic [3:0]         bus_be,
  input  logic               bus_ack,
  output logic               misalign_err,
  output logic               bus_err,
  output logic               idle
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               misalign_q, misalign_d;
  logic               bus_err_q, bus_err_d;
  store_entry_t       last_q;
  store_entry_t       head, entry_in, shown;
  logic               full, empty;
  logic [CW-1:0]      count;
  logic               accept, legal, push, pop, timeout_hit;

  assign wr_ready = !full;
  assign accept   = wr_valid && wr_ready;
  assign legal    = store_legal(wr_addr[1:0], wr_size);
  assign push     = accept && legal;
  assign entry_in = format_store(wr_addr, wr_data, wr_size);

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (entry_in),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Bus FSM next-state: ack or timeout pops the head; stay in REQ while
  // anything remains, counting a same-edge enqueue as remaining.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    misalign_d  = accept && !legal;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty || push) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus_ack) begin
          pop = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          pop         = 1'b1;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (pop) begin
          cnt_d = '0;
          if ((count == CW'(1)) && !push) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bus_err_d = timeout_hit;
  end

  // FSM, counter and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Remember the last driven entry so the bus fields hold while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (state_q == ST_REQ) begin
      last_q <= head;
    end
  end

  assign bus_req      = (state_q == ST_REQ);
  assign shown        = bus_req ? head : last_q;
  assign bus_addr     = shown.addr;
  assign bus_wdata    = shown.wdata;
  assign bus_be       = shown.be;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;
  assign idle         = empty && (state_q == ST_IDLE);

endmodule
